// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer.
//   seq_state_t   - sequencer state encoding
//   SEQ_NOP       - word shown to the datapath outside the execute cycle
//   SEQ_HALT_WORD - instruction word that halts the sequencer
//   OPC_*         - opcodes accepted when the illegal-opcode trap is built in
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_EXEC,
        ST_HALT
    } seq_state_t;

    localparam logic [31:0] SEQ_NOP       = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] SEQ_HALT_WORD = 32'h0000_0000;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/seq_opcode_check.sv
// Combinational opcode legality check used by the illegal-opcode trap.
// Ports:
//   opcode  in  7  IR[6:0] of the instruction in execute
//   legal   out 1  opcode is OP-IMM or OP
module seq_opcode_check
    import seq_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       legal
);

    assign legal = (opcode == OPC_OP_IMM) || (opcode == OPC_OP);

endmodule

// File: rtl/instruction_sequencer.sv
// Multi-cycle fetch/execute controller for a single-cycle RV32 datapath.
// Owns the PC, fetches one word per instruction over a valid/ready request
// plus a valid response, and presents it to the datapath for exactly one
// execute cycle. Outside that cycle the datapath sees a NOP.
//
// Optional feature: define SEQ_ILLEGAL_TRAP_EN to halt on any opcode other
// than OP-IMM / OP (sets sticky illegal_insn). Undefined: no opcode check.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   run              level; leaves IDLE when high
//   stop             pulse; return to IDLE after the current instruction
//   imem_req_valid   fetch request valid (held until imem_req_ready)
//   imem_req_ready   memory accepts request
//   imem_addr        fetch address (= PC)
//   imem_rsp_valid   response valid (only looked at in WAIT)
//   imem_rsp_data    fetched instruction word
//   instruction      word driven into the datapath (NOP outside EXEC)
//   exec_valid       execute cycle; gates datapath register write
//   halted           sequencer in HALT
//   illegal_insn     sticky; HALT caused by illegal opcode
//   retired          count of executed instructions
//
// All outputs come from registers or decode of registered state only.
module instruction_sequencer
    import seq_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            stop,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [31:0]     instruction,
    output logic            exec_valid,
    output logic            halted,
    output logic            illegal_insn,
    output logic [31:0]     retired
);

    seq_state_t      state, state_next;
    logic [XLEN-1:0] pc;
    logic [31:0]     ir;
    logic            stop_pending, pending_next;
    logic            opcode_legal;
    logic            is_halt_word;
    logic            exec_ok;

`ifdef SEQ_ILLEGAL_TRAP_EN
    logic illegal_q;

    seq_opcode_check u_opcode_check (
        .opcode (ir[6:0]),
        .legal  (opcode_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (state == ST_EXEC && !is_halt_word && !opcode_legal) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal_insn = illegal_q;
`else
    assign opcode_legal = 1'b1;
    assign illegal_insn = 1'b0;
`endif

    assign is_halt_word = (ir == SEQ_HALT_WORD);
    // Only a real instruction retires; halt word and trapped opcodes do not.
    assign exec_ok      = (state == ST_EXEC) && !is_halt_word && opcode_legal;

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        pending_next = stop_pending | stop;
        case (state)
            ST_IDLE: begin
                if (run) begin
                    // Leaving IDLE consumes any pending stop; a stop arriving
                    // in the same cycle as run keeps us here.
                    pending_next = 1'b0;
                    state_next   = stop ? ST_IDLE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_req_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!exec_ok) begin
                    state_next = ST_HALT;
                end else if (stop_pending) begin
                    // A stop landing in this very cycle is kept for the next
                    // instruction rather than being lost with the clear.
                    state_next   = ST_IDLE;
                    pending_next = stop;
                end else begin
                    state_next = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            pc           <= RESET_PC;
            ir           <= SEQ_NOP;
            retired      <= '0;
            stop_pending <= 1'b0;
        end else begin
            state        <= state_next;
            stop_pending <= pending_next;
            if (state == ST_WAIT && imem_rsp_valid) begin
                ir <= imem_rsp_data;
            end
            if (exec_ok) begin
                pc      <= pc + XLEN'(4);
                retired <= retired + 32'd1;
            end
        end
    end

    assign imem_req_valid = (state == ST_FETCH);
    assign imem_addr      = pc;
    assign instruction    = (state == ST_EXEC) ? ir : SEQ_NOP;
    assign exec_valid     = exec_ok;
    assign halted         = (state == ST_HALT);

endmodule
